// File: rtl/noc_pkg.sv
// Shared NoC definitions for the merge select arbiter: flit geometry and the
// arbiter state encoding.
package noc_pkg;

  localparam int FLIT_W      = 9;
  localparam int TAIL_BIT    = FLIT_W - 1;
  localparam int TIMEOUT_W_D = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, and a tie goes to
// the input named by prio.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt,
  output logic       any
);

  assign any = |req;
  assign gnt = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/merge_select_arbiter.sv
// Packet-aware round-robin scheduler producing the 1-bit select token for the
// 2:1 flit merge; the grant is held per packet and only one token is in flight.
module merge_select_arbiter
  import noc_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_D
) (
  input  logic       CLK,
  input  logic       _RESET,
  input  logic       in0_valid,
  input  logic       in0_tail,
  input  logic       in1_valid,
  input  logic       in1_tail,
  output logic       sel_valid,
  output logic       sel_data,
  input  logic       sel_ready,
  input  logic       flit_done,
  output logic       lock_timeout,
  output arb_state_t dbg_state
);

  // Token channel: once sel_valid rises, sel_valid and sel_data are held
  // unchanged until sel_ready; a transfer happens when sel_valid & sel_ready.

  localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  arb_state_t           state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 outstanding_q, outstanding_d;
  logic                 tail_q, tail_d;
  logic                 sel_valid_q, sel_valid_d;
  logic                 sel_data_q, sel_data_d;
  logic                 rr_prio_q, rr_prio_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 lock_timeout_q, lock_timeout_d;

  logic pick_gnt, pick_any;
  logic fire, done, g_valid, g_tail, start, raise, wd_idle;

  rr_pick2 u_pick (
    .req  ({in1_valid, in0_valid}),
    .prio (rr_prio_q),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  assign fire    = sel_valid_q & sel_ready;
  // A flit_done with no token in flight is stray and ignored.
  assign done    = flit_done & outstanding_q;
  assign g_valid = gnt_q ? in1_valid : in0_valid;
  assign g_tail  = gnt_q ? in1_tail  : in0_tail;
  assign start   = (state_q == ARB_IDLE) & ~outstanding_q & pick_any;
  assign raise   = (state_q == ARB_LOCK) & ~outstanding_q & ~sel_valid_q & g_valid;
  assign wd_idle = (state_q == ARB_LOCK) & ~outstanding_q & ~g_valid;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (start) state_d = ARB_LOCK;
      ARB_LOCK: if (done && tail_q) state_d = ARB_IDLE;
    endcase
  end

  // Done is applied before fire, so a same-cycle fire leaves a token in flight.
  always_comb begin
    gnt_d          = gnt_q;
    outstanding_d  = outstanding_q;
    tail_d         = tail_q;
    sel_valid_d    = sel_valid_q;
    sel_data_d     = sel_data_q;
    rr_prio_d      = rr_prio_q;
    wd_cnt_d       = wd_cnt_q;
    lock_timeout_d = lock_timeout_q;

    if (done) begin
      outstanding_d = 1'b0;
      if (tail_q) rr_prio_d = ~gnt_q;
    end
    if (fire) begin
      outstanding_d = 1'b1;
      sel_valid_d   = 1'b0;
      tail_d        = g_tail;
    end
    if (start) begin
      gnt_d       = pick_gnt;
      sel_valid_d = 1'b1;
      sel_data_d  = pick_gnt;
    end else if (raise) begin
      sel_valid_d = 1'b1;
      sel_data_d  = gnt_q;
    end

    // The watchdog only flags a stalled lock; the lock itself is kept.
    if (state_d != ARB_LOCK || fire) begin
      wd_cnt_d = '0;
    end else if (wd_idle && wd_cnt_q != '1) begin
      wd_cnt_d = wd_cnt_q + WD_ONE;
    end
    if (wd_cnt_d == '1) lock_timeout_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      gnt_q          <= 1'b0;
      outstanding_q  <= 1'b0;
      tail_q         <= 1'b0;
      sel_valid_q    <= 1'b0;
      sel_data_q     <= 1'b0;
      rr_prio_q      <= 1'b0;
      wd_cnt_q       <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      gnt_q          <= gnt_d;
      outstanding_q  <= outstanding_d;
      tail_q         <= tail_d;
      sel_valid_q    <= sel_valid_d;
      sel_data_q     <= sel_data_d;
      rr_prio_q      <= rr_prio_d;
      wd_cnt_q       <= wd_cnt_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign sel_valid    = sel_valid_q;
  assign sel_data     = sel_data_q;
  assign lock_timeout = lock_timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_merge_select_arbiter.sv
// Bench for merge_select_arbiter: a small merge model feeds flit heads and
// flit_done pulses, and every token transfer is checked against expected tokens.
module tb_merge_select_arbiter;
  import noc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in0_valid, in0_tail, in1_valid, in1_tail;
  logic       sel_valid, sel_data, sel_ready, flit_done, lock_timeout;
  arb_state_t dbg_state;

  logic [0:0] exp_q[$];
  logic       src0_q[$];
  logic       src1_q[$];

  int   checks, errors;
  int   pend_cnt, done_lat, stall_cnt;
  logic pend_idx, stall_exp, any_v;

  merge_select_arbiter #(.TIMEOUT_W(8)) dut (
    .CLK          (clk),
    ._RESET       (rst_n),
    .in0_valid    (in0_valid),
    .in0_tail     (in0_tail),
    .in1_valid    (in1_valid),
    .in1_tail     (in1_tail),
    .sel_valid    (sel_valid),
    .sel_data     (sel_data),
    .sel_ready    (sel_ready),
    .flit_done    (flit_done),
    .lock_timeout (lock_timeout),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : global_bound
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: one expected token consumed per transfer
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sel_valid === 1'b1 && sel_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_token actual=%0d required=none", sel_data);
        end else begin
          chk("token_sel", {31'd0, sel_data}, {31'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic drive_heads();
    in0_valid = (src0_q.size() > 0);
    in0_tail  = in0_valid ? src0_q[0] : 1'b0;
    in1_valid = (src1_q.size() > 0);
    in1_tail  = in1_valid ? src1_q[0] : 1'b0;
  endtask

  // One cycle of the merge model; entered and left at posedge + 1.
  task automatic step();
    flit_done = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        flit_done = 1'b1;
        if (pend_idx) src1_q.delete(0);
        else          src0_q.delete(0);
      end
    end
    drive_heads();
    if (stall_cnt > 0 && sel_valid) begin
      chk("stall_hold", {31'd0, sel_data}, {31'd0, stall_exp});
      sel_ready = 1'b0;
      stall_cnt--;
    end else begin
      sel_ready = 1'b1;
    end
    if (sel_valid && sel_ready) begin
      chk("one_outstanding", pend_cnt, 0);
      pend_idx = sel_data;
      pend_cnt = done_lat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_quiet(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend_cnt != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("quiet_bound", {31'd0, n < max_cyc}, 1);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel_valid", {31'd0, sel_valid}, 0);
    chk("rst_sel_data", {31'd0, sel_data}, 0);
    chk("rst_timeout", {31'd0, lock_timeout}, 0);
    chk("rst_state", {31'd0, dbg_state}, {31'd0, ARB_IDLE});
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    pend_cnt  = 0;
    stall_cnt = 0;
    flit_done = 1'b0;
    sel_ready = 1'b1;
    drive_heads();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; flit_done = 1'b0; sel_ready = 1'b1;
    pend_cnt = 0; stall_cnt = 0; done_lat = 1; pend_idx = 1'b0; stall_exp = 1'b0;
    drive_heads();

    // reset state, then idle inputs for 20 clocks
    repeat (3) @(posedge clk);
    #1;
    chk("por_sel_valid", {31'd0, sel_valid}, 0);
    chk("por_sel_data", {31'd0, sel_data}, 0);
    chk("por_timeout", {31'd0, lock_timeout}, 0);
    release_reset();
    any_v = 1'b0;
    repeat (20) begin
      step();
      any_v |= sel_valid;
    end
    chk("idle_no_token", {31'd0, any_v}, 0);
    chk("idle_timeout", {31'd0, lock_timeout}, 0);

    // 3-flit packet on in0 with slow flit_done
    done_lat = 3;
    src0_q.push_back(1'b0); src0_q.push_back(1'b0); src0_q.push_back(1'b1);
    repeat (3) exp_q.push_back(1'b0);
    run_quiet(100);
    repeat (4) step();
    chk("pkt3_state_idle", {31'd0, dbg_state}, {31'd0, ARB_IDLE});
    chk("pkt3_exp_empty", exp_q.size(), 0);

    // both inputs hold 2-flit packets: grants alternate per packet from prio 0
    apply_reset();
    release_reset();
    done_lat = 1;
    repeat (2) begin
      src0_q.push_back(1'b0); src0_q.push_back(1'b1);
      src1_q.push_back(1'b0); src1_q.push_back(1'b1);
    end
    repeat (2) begin
      exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    end
    run_quiet(200);
    repeat (4) step();
    chk("rr_exp_empty", exp_q.size(), 0);
    chk("rr_state_idle", {31'd0, dbg_state}, {31'd0, ARB_IDLE});

    // token raised while sel_ready is held low for 5 clocks
    done_lat = 2;
    stall_cnt = 5;
    stall_exp = 1'b1;
    src1_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    run_quiet(100);
    repeat (4) step();
    chk("stall_consumed", stall_cnt, 0);
    chk("stall_exp_empty", exp_q.size(), 0);

    // lock on in1, in1 goes quiet: watchdog fires, in0 is never served
    src1_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    run_quiet(100);
    src0_q.push_back(1'b0); src0_q.push_back(1'b1);
    repeat (254) step();
    chk("wd_before_limit", {31'd0, lock_timeout}, 0);
    step();
    chk("wd_at_limit", {31'd0, lock_timeout}, 1);
    repeat (20) step();
    chk("wd_sticky", {31'd0, lock_timeout}, 1);
    chk("wd_still_locked", {31'd0, dbg_state}, {31'd0, ARB_LOCK});
    chk("wd_no_token", {31'd0, sel_valid}, 0);

    // in1 resumes its packet; reset lands while that token is outstanding
    done_lat = 8;
    src1_q.push_back(1'b0); src1_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    n = 0;
    while (pend_cnt == 0 && n < 30) begin
      step();
      n++;
    end
    chk("resume_fired", {31'd0, n < 30}, 1);
    apply_reset();
    src0_q.push_back(1'b1);
    src1_q.push_back(1'b1);
    drive_heads();
    any_v = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      any_v |= sel_valid;
    end
    chk("no_token_in_reset", {31'd0, any_v}, 0);
    done_lat = 1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    release_reset();
    run_quiet(100);
    repeat (4) step();
    chk("post_rst_exp_empty", exp_q.size(), 0);
    chk("post_rst_idle", {31'd0, dbg_state}, {31'd0, ARB_IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
